// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game controller and rng.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } phase_t;

  localparam logic [1:0] LVL_EASY = 2'b00;
  localparam logic [1:0] LVL_MED  = 2'b01;
  localparam logic [1:0] LVL_HARD = 2'b10;

  // Lowest set button bit selects the difficulty.
  function automatic logic [1:0] lvl_decode(input logic [2:0] btn);
    if (btn[0])      return LVL_EASY;
    else if (btn[1]) return LVL_MED;
    else             return LVL_HARD;
  endfunction

endpackage

// File: rtl/game_controller_sec_timer.sv
// One-second prescaler: tick on the cycle the count reaches CLK_HZ-1.
module sec_timer #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_MAX);

  // Counter clears on request, otherwise wraps at CNT_MAX while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Reaction-game sequencer: level latch, IDLE/COUNTDOWN/PLAY/OVER FSM,
// phase timer and optional high-score register (GAME_CTRL_HIGH_SCORE_EN).
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ            = 50_000_000,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned GAME_SECONDS      = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  lvl_btn,
  input  logic [11:0] score,
  output logic [1:0]  level,
  output logic        play,
  output logic        score_clr,
  output logic [7:0]  time_left,
  output logic        game_over,
  output logic [1:0]  phase,
  output logic [11:0] best_score,
  output logic        new_best
);

  localparam int unsigned TL_W = 8;
  localparam logic [TL_W-1:0] TL_CD   = TL_W'(COUNTDOWN_SECONDS);
  localparam logic [TL_W-1:0] TL_GAME = TL_W'(GAME_SECONDS);

  phase_t          phase_q, phase_d;
  logic [1:0]      level_d;
  logic [TL_W-1:0] tl_d;
  logic            score_clr_d;
  logic            play_d;
  logic            game_over_d;
  logic            tick;
  logic            tmr_en;
  logic            tmr_clr;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [11:0]     best_d;
  logic            nb_d;
`endif

  assign phase = phase_q;

  sec_timer #(.CLK_HZ(CLK_HZ)) u_sec_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tick (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    phase_d     = phase_q;
    level_d     = level;
    tl_d        = time_left;
    score_clr_d = 1'b0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
    best_d      = best_score;
    nb_d        = new_best;
`endif
    unique case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d     = COUNTDOWN;
          tl_d        = TL_CD;
          score_clr_d = 1'b1;
        end else if (|lvl_btn) begin
          level_d = lvl_decode(lvl_btn);
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (time_left == TL_W'(1)) begin
            phase_d = PLAY;
            tl_d    = TL_GAME;
          end else begin
            tl_d = time_left - TL_W'(1);
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (time_left == TL_W'(1)) begin
            phase_d = OVER;
            tl_d    = '0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
            if (score > best_score) begin
              best_d = score;
              nb_d   = 1'b1;
            end
`endif
          end else begin
            tl_d = time_left - TL_W'(1);
          end
        end
      end
      OVER: begin
        if (start) begin
          phase_d     = COUNTDOWN;
          tl_d        = TL_CD;
          score_clr_d = 1'b1;
`ifdef GAME_CTRL_HIGH_SCORE_EN
          nb_d        = 1'b0;
`endif
        end else if (|lvl_btn) begin
          phase_d = IDLE;
          level_d = lvl_decode(lvl_btn);
`ifdef GAME_CTRL_HIGH_SCORE_EN
          nb_d    = 1'b0;
`endif
        end
      end
      default: phase_d = IDLE;
    endcase
    play_d      = (phase_d == PLAY);
    game_over_d = (phase_d == OVER);
    tmr_en      = (phase_q == COUNTDOWN) || (phase_q == PLAY);
    tmr_clr     = (phase_d != phase_q) || !tmr_en;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= IDLE;
      level     <= LVL_EASY;
      play      <= 1'b0;
      score_clr <= 1'b0;
      time_left <= '0;
      game_over <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      level     <= level_d;
      play      <= play_d;
      score_clr <= score_clr_d;
      time_left <= tl_d;
      game_over <= game_over_d;
    end
  end

`ifdef GAME_CTRL_HIGH_SCORE_EN
  // High-score register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score <= '0;
      new_best   <= 1'b0;
    end else begin
      best_score <= best_d;
      new_best   <= nb_d;
    end
  end
`else
  logic unused_score;
  assign unused_score = ^score;
  assign best_score   = '0;
  assign new_best     = 1'b0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller against a seconds/cycles reference model.
`timescale 1ns/1ps
module tb_game_controller;

  localparam int HZ = 10;
  localparam int CD = 3;
  localparam int GS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  lvl_btn = 3'b000;
  logic [11:0] score = 12'd0;
  logic [1:0]  level;
  logic        play;
  logic        score_clr;
  logic [7:0]  time_left;
  logic        game_over;
  logic [1:0]  phase;
  logic [11:0] best_score;
  logic        new_best;

  always #5 clk = ~clk;

  game_controller #(
    .CLK_HZ(HZ), .COUNTDOWN_SECONDS(CD), .GAME_SECONDS(GS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lvl_btn(lvl_btn), .score(score),
    .level(level), .play(play), .score_clr(score_clr), .time_left(time_left),
    .game_over(game_over), .phase(phase), .best_score(best_score),
    .new_best(new_best)
  );

  typedef struct packed {
    logic [1:0]  phase;
    logic [1:0]  level;
    logic        play;
    logic        clr;
    logic [7:0]  tl;
    logic        go;
    logic [11:0] best;
    logic        nb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles elapsed in the timed phase.
  int m_phase = 0, m_level = 0, m_tl = 0, m_best = 0, m_nb = 0, m_clr = 0, m_cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int low_bit(input logic [2:0] b);
    if (b[0]) return 0;
    if (b[1]) return 1;
    return 2;
  endfunction

  task enter_cd();
    m_phase = 1; m_tl = CD; m_cyc = 0; m_clr = 1; m_nb = 0;
  endtask

  task model_step();
    m_clr = 0;
    if (rst) begin
      m_phase = 0; m_level = 0; m_tl = 0; m_best = 0; m_nb = 0; m_cyc = 0;
    end else begin
      case (m_phase)
        0: if (start) enter_cd(); else if (lvl_btn != 0) m_level = low_bit(lvl_btn);
        1: begin
          m_cyc++;
          if (m_cyc == CD * HZ) begin m_phase = 2; m_cyc = 0; m_tl = GS; end
          else m_tl = CD - m_cyc / HZ;
        end
        2: begin
          m_cyc++;
          if (m_cyc == GS * HZ) begin
            m_phase = 3; m_tl = 0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
            if (int'(score) > m_best) begin m_best = int'(score); m_nb = 1; end
`endif
          end else m_tl = GS - m_cyc / HZ;
        end
        default: begin
          if (start) enter_cd();
          else if (lvl_btn != 0) begin m_level = low_bit(lvl_btn); m_phase = 0; m_nb = 0; end
        end
      endcase
    end
  endtask

  task drive(input logic r, input logic s, input logic [2:0] l, input logic [11:0] sc);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; lvl_btn = l; score = sc;
    model_step();
    e.phase = 2'(m_phase); e.level = 2'(m_level);
    e.play = (m_phase == 2); e.clr = 1'(m_clr); e.tl = 8'(m_tl);
    e.go = (m_phase == 3); e.best = 12'(m_best); e.nb = 1'(m_nb);
    exp_q.push_back(e);
  endtask

  task idle(input int n, input logic [11:0] sc);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b000, sc);
  endtask

  // Monitor: compare every registered output after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("phase",      int'(phase),      int'(e.phase));
        check("level",      int'(level),      int'(e.level));
        check("play",       int'(play),       int'(e.play));
        check("score_clr",  int'(score_clr),  int'(e.clr));
        check("time_left",  int'(time_left),  int'(e.tl));
        check("game_over",  int'(game_over),  int'(e.go));
        check("best_score", int'(best_score), int'(e.best));
        check("new_best",   int'(new_best),   int'(e.nb));
      end
    end
  end

  initial begin
    logic       s;
    logic [2:0] l;
    logic       r;
    drive(1'b1, 1'b0, 3'b000, 12'd0);
    drive(1'b1, 1'b0, 3'b000, 12'd0);
    idle(2, 12'd0);
    // Level latch, lowest bit wins.
    drive(1'b0, 1'b0, 3'b100, 12'd0);
    idle(3, 12'd0);
    drive(1'b0, 1'b0, 3'b101, 12'd0);
    idle(3, 12'd0);
    // Game 1 with ignored pulses in countdown and play, ends with score 42.
    drive(1'b0, 1'b1, 3'b000, 12'd42);
    for (int i = 0; i < 85; i++)
      drive(1'b0, (i == 10) || (i == 40), (i == 10 || i == 45) ? 3'b010 : 3'b000, 12'd42);
    idle(4, 12'd42);
    // Start and level together in OVER: start wins, level kept. Game 2 ends with 17.
    drive(1'b0, 1'b1, 3'b010, 12'd17);
    idle(85, 12'd17);
    // Lone level press in OVER returns to IDLE.
    drive(1'b0, 1'b0, 3'b010, 12'd17);
    idle(3, 12'd17);
    // Reset mid-play.
    drive(1'b0, 1'b1, 3'b000, 12'd99);
    idle(50, 12'd99);
    drive(1'b1, 1'b0, 3'b000, 12'd99);
    idle(5, 12'd99);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      r = ($urandom_range(0, 799) == 0);
      drive(r, s, l, 12'($urandom_range(0, 4095)));
    end
    idle(2, 12'd0);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
